// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Brief    : Two-master AXI4 read-channel arbiter (m0 = icache, m1 = dcache)
//            sharing one downstream read slave. The winner's AR payload is
//            captured, replayed to the slave, and R beats are routed back to
//            the owner combinationally until the rlast handshake.
//            Optional feature: define ARB_RR_EN for round-robin arbitration;
//            otherwise fixed priority with FIXED_PRIO winning ties.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int FIXED_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst,
    // master 0 (icache)
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    output logic              m0_rlast,
    input  logic              m0_rready,
    // master 1 (dcache)
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    output logic              m1_rlast,
    input  logic              m1_rready,
    // slave
    output logic [ADDR_W-1:0] s_araddr,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    input  logic              s_rlast,
    output logic              s_rready,
    // status
    output logic              owner,
    output logic              busy,
    output logic              len_err
);

    localparam logic c_fixed_prio = (FIXED_PRIO != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_busy;
    logic              r_len_err;
    logic              r_s_arvalid;
    logic [8:0]        r_beat_cnt;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic [2:0]        r_arsize;
    logic [1:0]        r_arburst;

    logic              w_tie_winner;
    logic              w_winner;
    logic              w_any_req;
    logic              w_grant;
    logic              w_in_data;
    logic              w_owner_rready;
    logic              w_r_hs;
    logic              w_sel0;
    logic              w_sel1;
    logic [8:0]        w_beat_cnt_inc;
    logic [8:0]        w_beats_expected;

`ifdef ARB_RR_EN
    logic r_rr_ptr;

    assign w_tie_winner = r_rr_ptr;

    // Round-robin pointer: the master that loses this grant wins the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= c_fixed_prio;
        end else if (w_grant) begin
            r_rr_ptr <= ~w_winner;
        end
    end
`else
    assign w_tie_winner = c_fixed_prio;
`endif

    // Arbitration: a lone requester wins; ties go to the tie winner
    assign w_any_req  = m0_arvalid | m1_arvalid;
    assign w_winner   = (m0_arvalid & m1_arvalid) ? w_tie_winner : m1_arvalid;
    assign w_grant    = (r_state == ST_IDLE) & w_any_req;
    assign m0_arready = w_grant & ~w_winner;
    assign m1_arready = w_grant &  w_winner;

    // R channel is a pure pass-through to the owner while in the data phase
    assign w_in_data      = (r_state == ST_DATA);
    assign w_owner_rready = r_owner ? m1_rready : m0_rready;
    assign s_rready       = w_in_data & w_owner_rready;
    assign w_r_hs         = s_rvalid & s_rready;
    assign w_sel0         = w_in_data & ~r_owner;
    assign w_sel1         = w_in_data &  r_owner;

    assign m0_rvalid = w_sel0 & s_rvalid;
    assign m0_rdata  = w_sel0 ? s_rdata : '0;
    assign m0_rresp  = w_sel0 ? s_rresp : 2'b00;
    assign m0_rlast  = w_sel0 & s_rlast;
    assign m1_rvalid = w_sel1 & s_rvalid;
    assign m1_rdata  = w_sel1 ? s_rdata : '0;
    assign m1_rresp  = w_sel1 ? s_rresp : 2'b00;
    assign m1_rlast  = w_sel1 & s_rlast;

    // Beat count including the current beat versus the requested burst size
    assign w_beat_cnt_inc   = r_beat_cnt + 9'd1;
    assign w_beats_expected = {1'b0, r_arlen} + 9'd1;

    assign s_araddr  = r_araddr;
    assign s_arlen   = r_arlen;
    assign s_arsize  = r_arsize;
    assign s_arburst = r_arburst;
    assign s_arvalid = r_s_arvalid;
    assign owner     = r_owner;
    assign busy      = r_busy;
    assign len_err   = r_len_err;

    // Burst sequencer: grant/capture, AR replay, R routing until rlast
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_busy      <= 1'b0;
            r_len_err   <= 1'b0;
            r_s_arvalid <= 1'b0;
            r_beat_cnt  <= '0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_arsize    <= '0;
            r_arburst   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_ADDR;
                        r_owner     <= w_winner;
                        r_busy      <= 1'b1;
                        r_s_arvalid <= 1'b1;
                        r_araddr    <= w_winner ? m1_araddr  : m0_araddr;
                        r_arlen     <= w_winner ? m1_arlen   : m0_arlen;
                        r_arsize    <= w_winner ? m1_arsize  : m0_arsize;
                        r_arburst   <= w_winner ? m1_arburst : m0_arburst;
                    end
                end
                ST_ADDR: begin
                    if (s_arready) begin
                        r_state     <= ST_DATA;
                        r_s_arvalid <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (w_r_hs) begin
                        if (s_rlast) begin
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_beat_cnt <= '0;
                            if (w_beat_cnt_inc != w_beats_expected) begin
                                r_len_err <= 1'b1;
                            end
                        end else begin
                            r_beat_cnt <= w_beat_cnt_inc;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_s_arvalid <= 1'b0;
                    r_beat_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Brief    : Self-checking bench for axi_rd_arbiter. A transaction-level model
//            predicts every output each cycle; directed scenarios add literal
//            expectations, followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int FIXED_PRIO = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // master-side drive variables
    logic [ADDR_W-1:0] p_addr  [2] = '{default: '0};
    logic [7:0]        p_len   [2] = '{default: '0};
    logic [2:0]        p_size  [2] = '{default: '0};
    logic [1:0]        p_burst [2] = '{default: '0};
    logic              p_valid [2] = '{default: 1'b0};
    logic              p_rready[2] = '{default: 1'b0};

    logic [ADDR_W-1:0] m0_araddr, m1_araddr;
    logic [7:0]        m0_arlen, m1_arlen;
    logic [2:0]        m0_arsize, m1_arsize;
    logic [1:0]        m0_arburst, m1_arburst;
    logic              m0_arvalid, m1_arvalid, m0_rready, m1_rready;
    logic              m0_arready, m1_arready;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [1:0]        m0_rresp, m1_rresp;
    logic              m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic [ADDR_W-1:0] s_araddr;
    logic [7:0]        s_arlen;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic              s_arvalid, s_rready, owner, busy, len_err;
    logic              s_arready = 1'b0;
    logic [DATA_W-1:0] s_rdata   = '0;
    logic [1:0]        s_rresp   = 2'b00;
    logic              s_rvalid  = 1'b0;
    logic              s_rlast   = 1'b0;

    assign m0_araddr = p_addr[0];  assign m1_araddr = p_addr[1];
    assign m0_arlen  = p_len[0];   assign m1_arlen  = p_len[1];
    assign m0_arsize = p_size[0];  assign m1_arsize = p_size[1];
    assign m0_arburst = p_burst[0]; assign m1_arburst = p_burst[1];
    assign m0_arvalid = p_valid[0]; assign m1_arvalid = p_valid[1];
    assign m0_rready = p_rready[0]; assign m1_rready = p_rready[1];

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(FIXED_PRIO)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid),
        .m0_rlast(m0_rlast), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid),
        .m1_rlast(m1_rlast), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
        .s_rlast(s_rlast), .s_rready(s_rready),
        .owner(owner), .busy(busy), .len_err(len_err)
    );

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    int          req_prob[2];
    int          req_left[2];      // requests still to issue, -1 = unlimited
    int          rready_mode[2];   // 0 always, 1 random, 2 toggle
    bit          fix_addr_en;
    logic [31:0] fix_addr[2];
    int          fix_len;          // -1 = random length
    int          arready_delay;    // -1 = random s_arready
    int          rvalid_prob;
    int          short_by;         // -1 = random beat-count errors
    bit          stray_en;

    // bench bookkeeping
    bit   pend[2] = '{default: 1'b0};
    int   sq[$];                   // beats the slave will deliver per burst
    int   sl_beat = 0;
    bit   r_hold  = 1'b0;
    int   ar_wait = 0;
    int   cyc = 0;
    int   glog[$];
    int   dut_beats[2];
    int   rvcnt[2];
    int   first_gnt, sav_cyc, ar_stall;
    logic [31:0] sav_addr;

    // transaction-level reference model
    bit          m_active = 1'b0, m_addr_done = 1'b0, m_owner = 1'b0, m_len_err = 1'b0;
    bit          m_ptr = (FIXED_PRIO != 0);
    int          m_beats = 0;
    logic [31:0] m_addr = '0;
    logic [7:0]  m_len = '0;
    logic [2:0]  m_size = '0;
    logic [1:0]  m_burst = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_winner(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef ARB_RR_EN
            return m_ptr;
`else
            return (FIXED_PRIO != 0);
`endif
        end
        return r1;
    endfunction

    function automatic int nbeats(input int len);
        int n;
        if (short_by >= 0) begin
            n = len + 1 - short_by;
            if (n < 1) n = 1;
        end else if ($urandom_range(4) == 0) begin
            n = int'($urandom_range(len + 2, 1));
        end else begin
            n = len + 1;
        end
        return n;
    endfunction

    // Per-cycle compare against the model, then advance model and bench state
    always @(negedge clk) begin
        bit w, any, e_data, e_rr, e0, e1;
        cyc++;
        any    = m0_arvalid | m1_arvalid;
        w      = model_winner(m0_arvalid, m1_arvalid);
        e_data = m_active && m_addr_done;
        e_rr   = m_owner ? m1_rready : m0_rready;
        e0     = e_data && !m_owner;
        e1     = e_data && m_owner;
        chk("m0_arready", m0_arready, !m_active && any && !w);
        chk("m1_arready", m1_arready, !m_active && any && w);
        chk("s_arvalid", s_arvalid, m_active && !m_addr_done);
        chk("s_araddr", s_araddr, m_addr);
        chk("s_arlen", s_arlen, m_len);
        chk("s_arsize", s_arsize, m_size);
        chk("s_arburst", s_arburst, m_burst);
        chk("busy", busy, m_active);
        chk("owner", owner, m_owner);
        chk("len_err", len_err, m_len_err);
        chk("s_rready", s_rready, e_data && e_rr);
        chk("m0_rvalid", m0_rvalid, e0 && s_rvalid);
        chk("m0_rdata", m0_rdata, e0 ? s_rdata : 64'd0);
        chk("m0_rresp", m0_rresp, e0 ? s_rresp : 2'd0);
        chk("m0_rlast", m0_rlast, e0 && s_rlast);
        chk("m1_rvalid", m1_rvalid, e1 && s_rvalid);
        chk("m1_rdata", m1_rdata, e1 ? s_rdata : 64'd0);
        chk("m1_rresp", m1_rresp, e1 ? s_rresp : 2'd0);
        chk("m1_rlast", m1_rlast, e1 && s_rlast);

        if (rst) begin
            m_active = 0; m_addr_done = 0; m_owner = 0; m_len_err = 0; m_beats = 0;
            m_ptr = (FIXED_PRIO != 0);
            m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
        end else if (!m_active) begin
            if (any) begin
                m_active = 1; m_addr_done = 0; m_owner = w; m_ptr = !w;
                m_addr  = w ? m1_araddr  : m0_araddr;
                m_len   = w ? m1_arlen   : m0_arlen;
                m_size  = w ? m1_arsize  : m0_arsize;
                m_burst = w ? m1_arburst : m0_arburst;
            end
        end else if (!m_addr_done) begin
            if (s_arready) m_addr_done = 1;
        end else if (s_rvalid && e_rr) begin
            m_beats++;
            if (s_rlast) begin
                if (m_beats != int'(m_len) + 1) m_len_err = 1;
                m_active = 0; m_addr_done = 0; m_beats = 0;
            end
        end

        if (rst) begin
            pend[0] = 0; pend[1] = 0; sq.delete(); sl_beat = 0; r_hold = 0; ar_wait = 0;
        end else begin
            if (m0_arvalid && m0_arready) begin
                pend[0] = 0; glog.push_back(0);
                if (first_gnt < 0) first_gnt = cyc;
            end
            if (m1_arvalid && m1_arready) begin
                pend[1] = 0; glog.push_back(1);
            end
            if (s_arvalid && sav_cyc < 0) begin
                sav_cyc = cyc; sav_addr = s_araddr;
            end
            if (s_arvalid && !s_arready) begin
                ar_stall++; ar_wait++;
            end
            if (s_arvalid && s_arready) begin
                ar_wait = 0; sq.push_back(nbeats(int'(s_arlen)));
            end
            if (m0_rvalid) rvcnt[0]++;
            if (m1_rvalid) rvcnt[1]++;
            if (m0_rvalid && m0_rready) dut_beats[0]++;
            if (m1_rvalid && m1_rready) dut_beats[1]++;
            if (sq.size() > 0 && s_rvalid) begin
                if (s_rready) begin
                    r_hold = 0;
                    if (sl_beat == sq[0] - 1) begin
                        void'(sq.pop_front()); sl_beat = 0;
                    end else begin
                        sl_beat++;
                    end
                end else begin
                    r_hold = 1;
                end
            end else begin
                r_hold = 0;
            end
        end
    end

    // Master and slave drivers, updated just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && req_left[n] != 0 && $urandom_range(99) < req_prob[n]) begin
                    pend[n] = 1;
                    if (req_left[n] > 0) req_left[n]--;
                    p_addr[n]  = fix_addr_en ? fix_addr[n] : $urandom;
                    p_len[n]   = (fix_len >= 0) ? 8'(fix_len) : 8'($urandom_range(15));
                    p_size[n]  = 3'($urandom_range(7));
                    p_burst[n] = 2'($urandom_range(3));
                end
                p_valid[n] = pend[n];
                case (rready_mode[n])
                    0:       p_rready[n] = 1'b1;
                    1:       p_rready[n] = ($urandom_range(1) == 1);
                    default: p_rready[n] = !p_rready[n];
                endcase
            end
            s_arready = (arready_delay >= 0) ? (ar_wait >= arready_delay) : ($urandom_range(1) == 1);
            if (sq.size() > 0) begin
                if (!r_hold) begin
                    s_rvalid = ($urandom_range(99) < rvalid_prob);
                    s_rdata  = {$urandom, $urandom};
                    s_rresp  = 2'($urandom_range(3));
                    s_rlast  = (sl_beat == sq[0] - 1);
                end
            end else begin
                s_rvalid = stray_en && ($urandom_range(7) == 0);
                s_rdata  = {$urandom, $urandom};
                s_rresp  = 2'($urandom_range(3));
                s_rlast  = ($urandom_range(1) == 1);
            end
        end
    end

    task automatic set_defaults();
        req_prob = '{100, 100}; req_left = '{0, 0}; rready_mode = '{0, 0};
        fix_addr_en = 0; fix_addr = '{32'd0, 32'd0}; fix_len = 7;
        arready_delay = 0; rvalid_prob = 100; short_by = 0; stray_en = 0;
    endtask

    task automatic clear_logs();
        glog.delete(); dut_beats = '{0, 0}; rvcnt = '{0, 0};
        first_gnt = -1; sav_cyc = -1; ar_stall = 0; sav_addr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int k;
        k = 0;
        do begin
            @(posedge clk); #2; k++;
        end while ((busy || pend[0] || pend[1] || req_left[0] != 0 || req_left[1] != 0) && k < max);
        checks++;
        if (k >= max) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, k);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic chk_grants(input string name, input int e[$]);
        chk({name, "_ngrants"}, glog.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            chk($sformatf("%s_grant%0d", name, i), (i < glog.size()) ? glog[i] : 9, e[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int eq[$];
        set_defaults();
        clear_logs();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk); #2;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_araddr", s_araddr, 0);

        // single icache request, 8-beat line fill
        clear_logs();
        fix_addr_en = 1; fix_addr[0] = 32'h8000_0040; req_left[0] = 1;
        wait_idle("t1", 300);
        eq = '{0};
        chk_grants("t1", eq);
        chk("t1_latency", sav_cyc - first_gnt, 1);
        chk("t1_s_araddr", sav_addr, 32'h8000_0040);
        chk("t1_m0_beats", dut_beats[0], 8);
        chk("t1_m1_rvalid_cycles", rvcnt[1], 0);
        chk("t1_busy", busy, 0);

        // simultaneous requests, m1 requests three times
        do_reset(); set_defaults(); clear_logs();
        req_left = '{1, 3};
        wait_idle("t2", 500);
`ifdef ARB_RR_EN
        eq = '{1, 0, 1, 1};
`else
        eq = '{1, 1, 1, 0};
`endif
        chk_grants("t2", eq);

        // both masters requesting continuously
        do_reset(); set_defaults(); clear_logs();
        req_left = '{3, 3};
        wait_idle("t3", 800);
`ifdef ARB_RR_EN
        eq = '{1, 0, 1, 0, 1, 0};
`else
        eq = '{1, 1, 1, 0, 0, 0};
`endif
        chk_grants("t3", eq);
        chk("t3_m0_beats", dut_beats[0], 24);
        chk("t3_m1_beats", dut_beats[1], 24);

        // slave stalls AR for five cycles
        do_reset(); set_defaults(); clear_logs();
        fix_len = 3; arready_delay = 5; req_left[0] = 1;
        wait_idle("t4", 300);
        chk("t4_ar_stall_cycles", ar_stall, 5);
        chk("t4_m0_beats", dut_beats[0], 4);
        chk("t4_len_err", len_err, 0);

        // toggling rready and a burst two beats short
        do_reset(); set_defaults(); clear_logs();
        rready_mode[0] = 2; short_by = 2; req_left[0] = 1;
        wait_idle("t5", 300);
        chk("t5_m0_beats", dut_beats[0], 6);
        chk("t5_len_err", len_err, 1);

        // reset in the middle of a burst, then a fresh dcache request
        set_defaults(); clear_logs();
        req_left[0] = 1;
        for (int k = 0; k < 200 && dut_beats[0] < 3; k++) begin
            @(posedge clk); #2;
        end
        chk("t6_reached_beat3", dut_beats[0], 3);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("t6_busy", busy, 0);
        chk("t6_s_rready", s_rready, 0);
        chk("t6_len_err", len_err, 0);
        rst = 1'b0;
        clear_logs();
        req_left[1] = 1;
        wait_idle("t6", 300);
        eq = '{1};
        chk_grants("t6", eq);
        chk("t6_m1_beats", dut_beats[1], 8);
        chk("t6_m0_beats", dut_beats[0], 0);

        // randomized traffic with occasional resets
        set_defaults(); clear_logs();
        req_prob = '{60, 60}; req_left = '{-1, -1}; rready_mode = '{1, 1};
        fix_len = -1; arready_delay = -1; rvalid_prob = 70; short_by = -1; stray_en = 1;
        repeat (3000) begin
            @(posedge clk); #2;
            rst = ($urandom_range(399) == 0);
        end
        rst = 1'b0;
        req_left = '{0, 0};
        wait_idle("drain", 3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
